// File: rtl/mul_seq_ctrl_if.sv
// rtl/mul_seq_ctrl_if.sv - handshake and multiplier bus bundle for mul_seq_ctrl
//
// Purpose: groups the upstream operand stream, the multiplier-side signals and
// the downstream product stream into one bundle.
//   slave  modport : the controller (mul_seq_ctrl) side
//   master modport : the environment side (operand source, multiplier, sink)
// Signals:
//   in_valid/in_ready/in_a/in_b  operand pair handshake
//   mul_a/mul_b/mul_start/mul_y  multiplier operands, start pulse, product
//   out_valid/out_ready/out_y    product handshake
//   busy                         controller not idle
interface mul_seq_ctrl_if #(
    parameter int N = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a;
    logic [N-1:0]   in_b;
    logic [N-1:0]   mul_a;
    logic [N-1:0]   mul_b;
    logic           mul_start;
    logic [2*N-1:0] mul_y;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_y;
    logic           busy;

    modport slave (
        input  in_valid, in_a, in_b, mul_y, out_ready,
        output in_ready, mul_a, mul_b, mul_start, out_valid, out_y, busy
    );

    modport master (
        output in_valid, in_a, in_b, mul_y, out_ready,
        input  in_ready, mul_a, mul_b, mul_start, out_valid, out_y, busy
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - flow-controlled start/wait/capture controller for a sequential multiplier
//
// Purpose: accepts operand pairs, holds them on the multiplier inputs, issues a
// one-cycle start pulse, waits WAIT cycles, captures the 2N-bit product and
// presents it downstream until accepted.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mul_seq_ctrl_if.slave (operand stream, multiplier bus, product stream, busy)
// Parameters:
//   N    - operand width
//   WAIT - cycles from start pulse until mul_y is valid (>= 1)
// Optional feature: define MUL_SEQ_CTRL_QUEUE_EN to add a one-entry operand
// queue so the next pair can be accepted while a product is in flight.
module mul_seq_ctrl #(
    parameter int N    = 4,
    parameter int WAIT = 5
) (
    input logic          clk,
    input logic          rst,
    mul_seq_ctrl_if.slave bus
);
    localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   mul_a_q, mul_a_d;
    logic [N-1:0]   mul_b_q, mul_b_d;
    logic           mul_start_q;
    logic [2*N-1:0] out_y_q, out_y_d;
    logic           in_ready;
    logic           in_hs;
    logic           out_hs;
    logic           out_valid;

`ifdef MUL_SEQ_CTRL_QUEUE_EN
    logic           q_valid_q, q_valid_d;
    logic [N-1:0]   q_a_q, q_a_d;
    logic [N-1:0]   q_b_q, q_b_d;

    // Outside IDLE the single queue slot is the only place a new pair can go.
    assign in_ready = (state_q == S_IDLE) || !q_valid_q;
`else
    assign in_ready = (state_q == S_IDLE);
`endif

    assign out_valid = (state_q == S_DONE);
    assign in_hs     = bus.in_valid && in_ready;
    assign out_hs    = out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        out_y_d = out_y_q;
`ifdef MUL_SEQ_CTRL_QUEUE_EN
        q_valid_d = q_valid_q;
        q_a_d     = q_a_q;
        q_b_d     = q_b_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_hs) begin
                    mul_a_d = bus.in_a;
                    mul_b_d = bus.in_b;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = CW'(WAIT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    out_y_d = bus.mul_y;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_hs) begin
                    state_d = S_IDLE;
`ifdef MUL_SEQ_CTRL_QUEUE_EN
                    // Chain straight into the next operation, skipping IDLE.
                    if (q_valid_q) begin
                        mul_a_d   = q_a_q;
                        mul_b_d   = q_b_q;
                        q_valid_d = 1'b0;
                        state_d   = S_START;
                    end else if (in_hs) begin
                        mul_a_d = bus.in_a;
                        mul_b_d = bus.in_b;
                        state_d = S_START;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef MUL_SEQ_CTRL_QUEUE_EN
        // A pair accepted while busy is parked, unless it went straight to the
        // multiplier on the output handshake edge above.
        if (in_hs && (state_q != S_IDLE) && !((state_q == S_DONE) && out_hs)) begin
            q_valid_d = 1'b1;
            q_a_d     = bus.in_a;
            q_b_d     = bus.in_b;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            out_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            // Registered so the pulse coincides exactly with the START state.
            mul_start_q <= (state_d == S_START);
            out_y_q     <= out_y_d;
        end
    end

`ifdef MUL_SEQ_CTRL_QUEUE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid_q <= 1'b0;
            q_a_q     <= '0;
            q_b_q     <= '0;
        end else begin
            q_valid_q <= q_valid_d;
            q_a_q     <= q_a_d;
            q_b_q     <= q_b_d;
        end
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.mul_start = mul_start_q;
    assign bus.out_valid = out_valid;
    assign bus.out_y     = out_y_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - self-checking bench for mul_seq_ctrl
module tb_mul_seq_ctrl;
    localparam int N    = 4;
    localparam int WAIT = 5;
    localparam int W    = 2 * N;
`ifdef MUL_SEQ_CTRL_QUEUE_EN
    localparam logic BP_READY  = 1'b1;
    localparam int   GAP       = WAIT + 2;
    localparam int   START_GAP = 1;
`else
    localparam logic BP_READY  = 1'b0;
    localparam int   GAP       = WAIT + 3;
    localparam int   START_GAP = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl_if #(.N(N)) ifc ();

    mul_seq_ctrl #(.N(N), .WAIT(WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Behavioural sequential multiplier: product appears on mul_y WAIT-1 edges
    // after the edge that samples the start pulse; before that mul_y is junk.
    logic [W-1:0] prod_m = '0;
    logic [W-1:0] junk_m = '0;
    int           age_m  = 1000;

    always @(posedge clk) begin
        junk_m <= W'($urandom);
        if (ifc.mul_start) begin
            prod_m <= {{N{1'b0}}, ifc.mul_a} * {{N{1'b0}}, ifc.mul_b};
            age_m  <= 0;
        end else if (age_m < 1000) begin
            age_m <= age_m + 1;
        end
    end

    assign ifc.mul_y = (age_m >= WAIT - 1) ? prod_m : (prod_m ^ (junk_m | W'(1)));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers a pair until accepted; returns in the cycle after the accept edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, output int waited);
        ifc.in_valid = 1'b1;
        ifc.in_a     = a;
        ifc.in_b     = b;
        waited       = 0;
        while (!ifc.in_ready && waited < 100) begin
            step();
            waited++;
        end
        step();
        ifc.in_valid = 1'b0;
        ifc.in_a     = N'($urandom);
        ifc.in_b     = N'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!ifc.out_valid && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({ifc.in_ready, ifc.out_valid, ifc.mul_start, ifc.busy} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 1000", {ifc.in_ready, ifc.out_valid, ifc.mul_start, ifc.busy});
        end
        checks++;
        if ({ifc.mul_a, ifc.mul_b, ifc.out_y} !== '0) begin
            failures++;
            $display("FAIL reset_data: got a=%0d b=%0d y=%0d expected 0", ifc.mul_a, ifc.mul_b, ifc.out_y);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_latency(input logic [N-1:0] a, input logic [N-1:0] b);
        int w;
        int exp_p;
        exp_p = int'(a) * int'(b);
        ifc.out_ready = 1'b1;
        send(a, b, w);
        checks++;
        if (w >= 100) begin
            failures++;
            $display("FAIL accept_timeout: waited %0d expected <100", w);
        end
        checks++;
        if ({ifc.mul_start, ifc.busy, ifc.out_valid} !== 3'b110) begin
            failures++;
            $display("FAIL start_cycle: got %b expected 110", {ifc.mul_start, ifc.busy, ifc.out_valid});
        end
        for (int k = 1; k <= WAIT; k++) begin
            checks++;
            if ({ifc.mul_a, ifc.mul_b} !== {a, b}) begin
                failures++;
                $display("FAIL operand_hold: got %0d,%0d expected %0d,%0d", ifc.mul_a, ifc.mul_b, a, b);
            end
            step();
            checks++;
            if ({ifc.mul_start, ifc.busy, ifc.out_valid} !== 3'b010) begin
                failures++;
                $display("FAIL wait_cycle%0d: got %b expected 010", k, {ifc.mul_start, ifc.busy, ifc.out_valid});
            end
        end
        step();
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_y !== W'(exp_p)) begin
            failures++;
            $display("FAIL product_%0dx%0d: got valid=%b y=%0d expected valid=1 y=%0d", a, b, ifc.out_valid, ifc.out_y, exp_p);
        end
        step();
        checks++;
        if ({ifc.out_valid, ifc.busy, ifc.in_ready} !== 3'b001) begin
            failures++;
            $display("FAIL after_handshake: got %b expected 001", {ifc.out_valid, ifc.busy, ifc.in_ready});
        end
    endtask

    task automatic test_zero();
        logic [N-1:0] av [2];
        logic [N-1:0] bv [2];
        int w;
        int n;
        av[0] = 0; bv[0] = 9;
        av[1] = 9; bv[1] = 0;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(av[i], bv[i], w);
            wait_valid(n);
            checks++;
            if (ifc.out_valid !== 1'b1 || ifc.out_y !== '0) begin
                failures++;
                $display("FAIL zero_%0d: got valid=%b y=%0d expected valid=1 y=0", i, ifc.out_valid, ifc.out_y);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int w;
        int n;
        ifc.out_ready = 1'b0;
        send(6, 7, w);
        wait_valid(n);
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL bp_timeout: waited %0d expected <50", n);
        end
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (ifc.out_valid !== 1'b1 || ifc.out_y !== W'(42)) begin
                failures++;
                $display("FAIL bp_hold%0d: got valid=%b y=%0d expected valid=1 y=42", k, ifc.out_valid, ifc.out_y);
            end
            step();
        end
        checks++;
        if (ifc.in_ready !== BP_READY) begin
            failures++;
            $display("FAIL bp_in_ready: got %b expected %b", ifc.in_ready, BP_READY);
        end
        ifc.out_ready = 1'b1;
        step();
        checks++;
        if ({ifc.out_valid, ifc.busy} !== 2'b00) begin
            failures++;
            $display("FAIL bp_release: got %b expected 00", {ifc.out_valid, ifc.busy});
        end
        step();
        checks++;
        if (ifc.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_single_hs: got valid=%b expected 0", ifc.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        int n;
        ifc.out_ready = 1'b1;
        send(12, 11, w);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ifc.out_valid, ifc.mul_start, ifc.in_ready, ifc.busy} !== 4'b0010 || ifc.out_y !== '0) begin
            failures++;
            $display("FAIL mid_reset: got ctrl=%b y=%0d expected ctrl=0010 y=0",
                     {ifc.out_valid, ifc.mul_start, ifc.in_ready, ifc.busy}, ifc.out_y);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        send(2, 3, w);
        wait_valid(n);
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_y !== W'(6)) begin
            failures++;
            $display("FAIL post_reset_product: got valid=%b y=%0d expected valid=1 y=6", ifc.out_valid, ifc.out_y);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int got [$];
        int hs_cyc [$];
        int st_cyc [$];
        int idx;
        logic acc;
        idx = 0;
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.in_a      = 2;
        ifc.in_b      = 2;
        for (int cyc = 0; cyc < 200 && got.size() < 3; cyc++) begin
            acc = ifc.in_valid && ifc.in_ready;
            if (ifc.out_valid && ifc.out_ready) begin
                got.push_back(int'(ifc.out_y));
                hs_cyc.push_back(cyc);
            end
            if (ifc.mul_start) st_cyc.push_back(cyc);
            step();
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    ifc.in_a = N'(idx + 2);
                    ifc.in_b = N'(idx + 2);
                end else begin
                    ifc.in_valid = 1'b0;
                end
            end
        end
        checks++;
        if (got.size() != 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d products expected 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] != (i + 2) * (i + 2)) begin
                    failures++;
                    $display("FAIL b2b_value%0d: got %0d expected %0d", i, got[i], (i + 2) * (i + 2));
                end
            end
            checks++;
            if (hs_cyc[1] - hs_cyc[0] != GAP || hs_cyc[2] - hs_cyc[1] != GAP) begin
                failures++;
                $display("FAIL b2b_gap: got %0d,%0d expected %0d", hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1], GAP);
            end
            checks++;
            if (st_cyc.size() < 2 || st_cyc[1] != hs_cyc[0] + START_GAP) begin
                failures++;
                $display("FAIL b2b_start: got second start at %0d expected %0d",
                         (st_cyc.size() < 2) ? -1 : st_cyc[1], hs_cyc[0] + START_GAP);
            end
        end
    endtask

    task automatic test_random();
        int exp_q [$];
        int sent;
        int recv;
        logic acc;
        logic ohs;
        sent = 0;
        recv = 0;
        ifc.in_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && recv < 20; cyc++) begin
            if (!ifc.in_valid && sent < 20 && ($urandom % 3) != 0) begin
                ifc.in_valid = 1'b1;
                ifc.in_a     = N'($urandom);
                ifc.in_b     = N'($urandom);
            end
            ifc.out_ready = 1'($urandom % 2);
            acc = ifc.in_valid && ifc.in_ready;
            ohs = ifc.out_valid && ifc.out_ready;
            if (acc) exp_q.push_back(int'(ifc.in_a) * int'(ifc.in_b));
            if (ohs) begin
                recv++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra: got y=%0d expected no product", ifc.out_y);
                end else begin
                    if (int'(ifc.out_y) != exp_q[0]) begin
                        failures++;
                        $display("FAIL rand_value%0d: got %0d expected %0d", recv, ifc.out_y, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            step();
            if (acc) begin
                ifc.in_valid = 1'b0;
                sent++;
            end
        end
        checks++;
        if (recv != 20) begin
            failures++;
            $display("FAIL rand_count: got %0d expected 20", recv);
        end
        ifc.out_ready = 1'b1;
    endtask

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.in_a      = '0;
        ifc.in_b      = '0;
        ifc.out_ready = 1'b0;
        test_reset();
        test_latency(3, 5);
        test_latency(15, 15);
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
